// File: rtl/dffram_pkg.sv
// dffram_pkg
// Shared definitions for the DFFRAM Wishbone controller slice.
//   state_t        controller FSM states (CLEAR exists only when the build
//                  defines DFFRAM_WB_CTRL_CLEAR_EN)
//   WORD_W         RAM word width in bits
//   calc_a_width   word-address width for a RAM of WSIZE kilobytes
package dffram_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_WAIT,
        RD_ACK,
        CLEAR
    } state_t;

    // 1 KB holds 256 32-bit words, so each doubling of WSIZE adds one bit.
    function automatic int calc_a_width(input int wsize);
        return 8 + $clog2(wsize);
    endfunction

endpackage

// File: rtl/dffram_clear_seq.sv
// dffram_clear_seq
// Word counter for the post-reset RAM clear sweep. It walks addresses
// 0..2**A_WIDTH-1 one word per cycle while run is high.
// Ports:
//   CLK    in   clock
//   RST_N  in   synchronous active-low reset (restarts the sweep at word 0)
//   run    in   controller is in its clear state; advance the counter
//   addr   out  word currently being cleared
//   busy   out  sweep not yet finished (high straight out of reset)
//   done   out  last word is being written this cycle
module dffram_clear_seq
    import dffram_pkg::*;
#(
    parameter int A_WIDTH = 10
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               run,
    output logic [A_WIDTH-1:0] addr,
    output logic               busy,
    output logic               done
);

    localparam logic [A_WIDTH-1:0] ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

    logic [A_WIDTH-1:0] cnt;
    logic               busy_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q && run) begin
            cnt <= cnt + ONE;
            if (&cnt) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign addr = cnt;
    assign busy = busy_q;
    assign done = busy_q & run & (&cnt);

endmodule

// File: rtl/dffram_wb_ctrl.sv
// dffram_wb_ctrl
// Wishbone classic slave driving one DFFRAM macro port. Single-beat reads
// and writes are translated into EN/WE/A/Di; Do is captured one cycle after
// EN and returned with the acknowledge.
// Build option: define DFFRAM_WB_CTRL_CLEAR_EN to zero the whole RAM after
// every reset release (clr_busy_o high during the sweep, bus requests held
// off until it ends). Without it clr_busy_o is tied low.
// Ports:
//   CLK, RST_N      clock and synchronous active-low reset
//   wbs_cyc_i/stb_i bus request (sampled only while idle)
//   wbs_we_i        1 = write
//   wbs_sel_i       byte lanes, passed straight to RAM WE
//   wbs_adr_i       byte address; bits [A_WIDTH+1:2] select the word
//   wbs_dat_i       write data
//   wbs_ack_o       one-cycle acknowledge (suppressed if cyc drops)
//   wbs_dat_o       registered read data, held until the next read
//   ram_en_o/we_o/a_o/di_o  macro controls
//   ram_do_i        macro read data
//   clr_busy_o      clear sweep in progress
module dffram_wb_ctrl
    import dffram_pkg::*;
#(
    parameter  int WSIZE   = 4,
    localparam int A_WIDTH = calc_a_width(WSIZE)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               ram_en_o,
    output logic [3:0]         ram_we_o,
    output logic [A_WIDTH-1:0] ram_a_o,
    output logic [31:0]        ram_di_o,
    input  logic [31:0]        ram_do_i,
    output logic               clr_busy_o
);

    state_t              state;
    state_t              state_nxt;
    logic                req;
    logic [A_WIDTH-1:0]  adr_word;
    logic [WORD_W-1:0]   rd_dat_p1;

    // Upstream decode owns the high address bits; the byte offset is
    // meaningless for a word-wide RAM.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:A_WIDTH+2], wbs_adr_i[1:0]};

    // Qualifying with RST_N keeps the combinational RAM controls quiet
    // while reset is held, even if the bus is mid-request.
    assign req      = wbs_cyc_i & wbs_stb_i & RST_N;
    assign adr_word = wbs_adr_i[A_WIDTH+1:2];

`ifdef DFFRAM_WB_CTRL_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;

    logic               clr_run;
    logic               clr_done;
    logic [A_WIDTH-1:0] clr_addr;

    assign clr_run = (state == CLEAR);

    dffram_clear_seq #(
        .A_WIDTH (A_WIDTH)
    ) u_clear_seq (
        .CLK   (CLK),
        .RST_N (RST_N),
        .run   (clr_run),
        .addr  (clr_addr),
        .busy  (clr_busy_o),
        .done  (clr_done)
    );
`else
    localparam state_t RESET_STATE = IDLE;

    assign clr_busy_o = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= RESET_STATE;
            rd_dat_p1 <= '0;
        end else begin
            state <= state_nxt;
            // Do is valid in the cycle after EN; capture it even if the
            // master has already abandoned the read.
            if (state == RD_WAIT) begin
                rd_dat_p1 <= ram_do_i;
            end
        end
    end

    assign wbs_dat_o = rd_dat_p1;

    always_comb begin
        state_nxt = state;
        wbs_ack_o = 1'b0;
        ram_en_o  = 1'b0;
        ram_we_o  = 4'h0;
        ram_a_o   = '0;
        ram_di_o  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    ram_en_o = 1'b1;
                    ram_a_o  = adr_word;
                    if (wbs_we_i) begin
                        ram_we_o  = wbs_sel_i;
                        ram_di_o  = wbs_dat_i;
                        state_nxt = WR_ACK;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_nxt = wbs_cyc_i ? RD_ACK : IDLE;
            end
            WR_ACK, RD_ACK: begin
                // A master that dropped cyc gets no acknowledge.
                wbs_ack_o = wbs_cyc_i;
                state_nxt = IDLE;
            end
`ifdef DFFRAM_WB_CTRL_CLEAR_EN
            CLEAR: begin
                if (RST_N) begin
                    ram_en_o = 1'b1;
                    ram_we_o = 4'hF;
                    ram_a_o  = clr_addr;
                end
                if (clr_done) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dffram_wb_ctrl.sv
`timescale 1ns/1ps
module tb_dffram_wb_ctrl;

`ifdef DFFRAM_WB_CTRL_CLEAR_EN
    localparam int WSIZE   = 1;
    localparam bit CLR_ON  = 1'b1;
`else
    localparam int WSIZE   = 4;
    localparam bit CLR_ON  = 1'b0;
`endif
    localparam int AW     = 8 + $clog2(WSIZE);
    localparam int NWORDS = 256 * WSIZE;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          ram_en_o;
    logic [3:0]    ram_we_o;
    logic [AW-1:0] ram_a_o;
    logic [31:0]   ram_di_o;
    logic [31:0]   ram_do;
    logic          clr_busy_o;

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    dffram_wb_ctrl #(.WSIZE(WSIZE)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_a_o    (ram_a_o),
        .ram_di_o   (ram_di_o),
        .ram_do_i   (ram_do),
        .clr_busy_o (clr_busy_o)
    );

    // Behavioural DFFRAM macro: Do registered on EN, zero after an EN=0 edge.
    // Power-up contents are a seeded pattern the reference model also knows.
    logic [31:0] seed;
    logic [31:0] ram [NWORDS];
    logic        ram_filled = 1'b0;

    function automatic logic [31:0] fill_val(input int i);
        logic [31:0] iv;
        iv = i;
        return (iv * 32'h9E3779B1) ^ seed;
    endfunction

    always @(posedge CLK) begin
        if (!ram_filled) begin
            for (int i = 0; i < NWORDS; i++) ram[i] <= fill_val(i);
            ram_filled <= 1'b1;
            ram_do <= '0;
        end else if (ram_en_o) begin
            ram_do <= ram[ram_a_o];
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) ram[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    // Reference model: expected RAM contents as seen through the bus.
    logic [31:0] shadow [NWORDS];

    function automatic int word_of(input logic [31:0] adr);
        return int'((adr >> 2) % NWORDS);
    endfunction

    task automatic bus_idle;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
    endtask

    task automatic release_reset;
        int n;
        RST_N = 1'b1;
        if (CLR_ON) begin
            n = 0;
            while (clr_busy_o === 1'b1 && n < NWORDS + 20) begin
                @(negedge CLK); n++;
            end
            total++;
            if (n !== NWORDS) $display("FAIL clr_sweep_len: got %0d cycles want %0d", n, NWORDS);
            else passed++;
            for (int i = 0; i < NWORDS; i++) shadow[i] = 32'h0;
        end
    endtask

    task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [AW-1:0] wa;
        int w;
        w  = word_of(adr);
        wa = AW'(w);
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        #1;
        total++;
        if ({ram_en_o, ram_we_o, ram_a_o, ram_di_o} !== {1'b1, sel, wa, dat})
            $display("FAIL wr_ram_ctrl: got en=%b we=%h a=%h di=%h want en=1 we=%h a=%h di=%h",
                     ram_en_o, ram_we_o, ram_a_o, ram_di_o, sel, wa, dat);
        else passed++;
        @(negedge CLK);
        total++;
        if ({wbs_ack_o, ram_en_o, ram_we_o} !== {1'b1, 1'b0, 4'h0})
            $display("FAIL wr_ack_n1: got ack=%b en=%b we=%h want ack=1 en=0 we=0",
                     wbs_ack_o, ram_en_o, ram_we_o);
        else passed++;
        bus_idle();
        for (int b = 0; b < 4; b++)
            if (sel[b]) shadow[w][b*8 +: 8] = dat[b*8 +: 8];
    endtask

    task automatic bus_read(input logic [31:0] adr, output logic [31:0] d);
        logic [AW-1:0] wa;
        wa = AW'(word_of(adr));
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = adr;  wbs_sel_i = 4'hF;
        #1;
        total++;
        if ({ram_en_o, ram_we_o, ram_a_o} !== {1'b1, 4'h0, wa})
            $display("FAIL rd_ram_ctrl: got en=%b we=%h a=%h want en=1 we=0 a=%h",
                     ram_en_o, ram_we_o, ram_a_o, wa);
        else passed++;
        @(negedge CLK);
        total++;
        if ({wbs_ack_o, ram_en_o} !== 2'b00)
            $display("FAIL rd_wait_n1: got ack=%b en=%b want ack=0 en=0", wbs_ack_o, ram_en_o);
        else passed++;
        @(negedge CLK);
        total++;
        if (wbs_ack_o !== 1'b1) $display("FAIL rd_ack_n2: got ack=%b want 1", wbs_ack_o);
        else passed++;
        d = wbs_dat_o;
        bus_idle();
    endtask

    task automatic test_reset;
        bus_idle();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({wbs_ack_o, wbs_dat_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o, clr_busy_o} !==
            {1'b0, 32'h0, 1'b0, 4'h0, {AW{1'b0}}, 32'h0, CLR_ON})
            $display("FAIL reset_values: got ack=%b dat=%h en=%b we=%h a=%h di=%h busy=%b want all 0 busy=%b",
                     wbs_ack_o, wbs_dat_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o, clr_busy_o, CLR_ON);
        else passed++;
        release_reset();
    endtask

    task automatic test_basic;
        logic [31:0] d;
        bus_write(32'h10, 32'hDEADBEEF, 4'hF);
        bus_read(32'h10, d);
        total++;
        if (d !== 32'hDEADBEEF) $display("FAIL basic_rd: got %h want deadbeef", d);
        else passed++;
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        bus_write(32'h20, 32'h11223344, 4'hF);
        bus_write(32'h20, 32'h0000AA00, 4'b0010);
        bus_read(32'h20, d);
        total++;
        if (d !== 32'h1122AA44) $display("FAIL byte_lane: got %h want 1122aa44", d);
        else passed++;
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        bus_write(NWORDS * 4, 32'h5, 4'hF);
        bus_read(32'h0, d);
        total++;
        if (d !== 32'h5) $display("FAIL addr_wrap: got %h want 00000005", d);
        else passed++;
    endtask

    task automatic test_sel_zero;
        logic [31:0] d;
        bus_write(32'h30, 32'hCAFEF00D, 4'hF);
        bus_write(32'h30, $urandom, 4'h0);
        bus_read(32'h30, d);
        total++;
        if (d !== 32'hCAFEF00D) $display("FAIL sel_zero_rd: got %h want cafef00d", d);
        else passed++;
    endtask

    task automatic test_random;
        logic [31:0] d, adr, last_rd;
        int w;
        adr = $urandom;
        bus_read(adr, last_rd);
        total++;
        if (last_rd !== shadow[word_of(adr)])
            $display("FAIL rand_rd0: got %h want %h", last_rd, shadow[word_of(adr)]);
        else passed++;
        for (int k = 0; k < 60; k++) begin
            adr = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 1) == 1) begin
                bus_write(adr, $urandom, 4'($urandom_range(0, 15)));
                total++;
                if (wbs_dat_o !== last_rd)
                    $display("FAIL rand_dat_hold: got %h want %h", wbs_dat_o, last_rd);
                else passed++;
            end else begin
                w = word_of(adr);
                bus_read(adr, d);
                total++;
                if (d !== shadow[w]) $display("FAIL rand_rd: word %0d got %h want %h", w, d, shadow[w]);
                else passed++;
                last_rd = d;
            end
        end
    endtask

    task automatic test_cyc_drop;
        logic [31:0] d;
        bus_write(32'h44, 32'h0BADF00D, 4'hF);
        bus_write(32'h48, 32'h12345678, 4'hF);
        bus_read(32'h48, d);
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h44;
        @(negedge CLK);
        bus_idle();
        @(negedge CLK);
        total++;
        if ({wbs_ack_o, wbs_dat_o} !== {1'b0, 32'h0BADF00D})
            $display("FAIL cyc_drop: got ack=%b dat=%h want ack=0 dat=0badf00d", wbs_ack_o, wbs_dat_o);
        else passed++;
        // Next request goes out right away in this idle cycle.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h4C; wbs_dat_i = 32'h600DCAFE; wbs_sel_i = 4'hF;
        @(negedge CLK);
        total++;
        if (wbs_ack_o !== 1'b1) $display("FAIL cyc_drop_next: got ack=%b want 1", wbs_ack_o);
        else passed++;
        bus_idle();
        shadow[word_of(32'h4C)] = 32'h600DCAFE;
        bus_read(32'h4C, d);
        total++;
        if (d !== 32'h600DCAFE) $display("FAIL cyc_drop_rd: got %h want 600dcafe", d);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_write(32'h50, 32'hA5A5A5A5, 4'hF);
        bus_read(32'h50, d);
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h50;
        @(negedge CLK);
        RST_N = 1'b0;
        bus_idle();
        @(negedge CLK);
        total++;
        if ({wbs_ack_o, wbs_dat_o, ram_en_o} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL reset_mid: got ack=%b dat=%h en=%b want ack=0 dat=0 en=0",
                     wbs_ack_o, wbs_dat_o, ram_en_o);
        else passed++;
        @(negedge CLK);
        release_reset();
        bus_read(32'h50, d);
        total++;
        if (d !== shadow[word_of(32'h50)])
            $display("FAIL reset_mid_rd: got %h want %h", d, shadow[word_of(32'h50)]);
        else passed++;
    endtask

    task automatic test_clear;
        int n, errs;
        bit acked;
        logic [31:0] d;
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h8;
        RST_N = 1'b1;
        n = 0; acked = 1'b0;
        while (clr_busy_o === 1'b1 && n < NWORDS + 20) begin
            @(negedge CLK); n++;
            if (wbs_ack_o === 1'b1 && clr_busy_o === 1'b1) acked = 1'b1;
        end
        total++;
        if ({acked, n} !== {1'b0, NWORDS})
            $display("FAIL clr_hold: got acked=%b len=%0d want acked=0 len=%0d", acked, n, NWORDS);
        else passed++;
        n = 0;
        while (wbs_ack_o !== 1'b1 && n < 6) begin @(negedge CLK); n++; end
        total++;
        if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h0})
            $display("FAIL clr_wait_rd: got ack=%b dat=%h want ack=1 dat=0", wbs_ack_o, wbs_dat_o);
        else passed++;
        bus_idle();
        for (int i = 0; i < NWORDS; i++) shadow[i] = 32'h0;
        errs = 0;
        for (int i = 0; i < NWORDS; i++) begin
            bus_read(i * 4, d);
            if (d !== 32'h0) begin
                if (errs < 4) $display("FAIL clr_word: word %0d got %h want 0", i, d);
                errs++;
            end
        end
        total++;
        if (errs !== 0) $display("FAIL clr_all: got %0d nonzero words want 0", errs);
        else passed++;
    endtask

    initial begin
        seed = $urandom;
        for (int i = 0; i < NWORDS; i++) shadow[i] = fill_val(i);
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wrap();
        test_sel_zero();
        test_random();
        test_cyc_drop();
        test_reset_mid();
        if (CLR_ON) test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
